// File: rtl/bus_grant_arbiter.sv
// Round-robin owner arbiter for the internal CPU bus: registered one-hot grant, 5-bit select,
// one dead cycle between owners and an optional hold limit. Define BUS_ARB_FIXED_PRI_EN for fixed priority.
module bus_grant_arbiter #(
    parameter int N        = 24,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic          clock,
    input  logic          clear,
    input  logic [N-1:0]  req,
    output logic [31:0]   grant,
    output logic [4:0]    bus_sel,
    output logic          busy,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    localparam int unsigned NU        = N;
    localparam int          IW        = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HOLD_LIM  = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIM);
    localparam logic [4:0]  SEL_NONE  = 5'd31;

    state_t            state;
    logic [4:0]        last_owner;
    logic [HOLD_W-1:0] hold_cnt;

    logic              found;
    logic [4:0]        win;
    logic              owner_req;
    logic              at_limit;

    // In GRANT, last_owner is the current owner.
    assign owner_req = req[IW'(last_owner)];
    assign at_limit  = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);

`ifdef BUS_ARB_FIXED_PRI_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (!found && req[IW'(i)]) begin
                found = 1'b1;
                win   = 5'(i);
            end
        end
    end
`else
    // Scan starts just after the previous owner so a still-pending ex-owner comes last.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            idx = (32'(last_owner) + 32'd1 + i) % NU;
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                win   = 5'(idx);
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            grant      <= '0;
            bus_sel    <= SEL_NONE;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            last_owner <= 5'(N - 1);
            hold_cnt   <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (found) begin
                        state      <= GRANT;
                        grant      <= 32'd1 << win;
                        bus_sel    <= win;
                        busy       <= 1'b1;
                        last_owner <= win;
                        hold_cnt   <= '0;
                    end else begin
                        state   <= IDLE;
                        grant   <= '0;
                        bus_sel <= SEL_NONE;
                        busy    <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state   <= TURN;
                        grant   <= '0;
                        bus_sel <= SEL_NONE;
                        busy    <= 1'b0;
                    end else if (at_limit) begin
                        state   <= TURN;
                        grant   <= '0;
                        bus_sel <= SEL_NONE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else if (MAX_HOLD > 0) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant   <= '0;
                    bus_sel <= SEL_NONE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Scoreboard bench for bus_grant_arbiter: one instance with the hold limit, one without.
module tb_bus_grant_arbiter;

    typedef struct {
        int          id;
        string       tag;
        logic [31:0] grant;
        logic [4:0]  sel;
        logic        busy;
        logic        to;
    } exp_t;

    logic        clock;
    logic        clear;
    logic [23:0] req_a, req_b;
    logic [31:0] grant_a, grant_b;
    logic [4:0]  sel_a, sel_b;
    logic        busy_a, busy_b, to_a, to_b;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    bus_grant_arbiter #(.N(24), .MAX_HOLD(8), .HOLD_W(4)) u_dut (
        .clock(clock), .clear(clear), .req(req_a),
        .grant(grant_a), .bus_sel(sel_a), .busy(busy_a), .timeout(to_a)
    );

    bus_grant_arbiter #(.N(24), .MAX_HOLD(0), .HOLD_W(4)) u_nohold (
        .clock(clock), .clear(clear), .req(req_b),
        .grant(grant_b), .bus_sel(sel_b), .busy(busy_b), .timeout(to_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish within time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t g(input int i, input string tag);
        exp_t e;
        e.id = 0; e.tag = tag;
        e.grant = 32'd1 << i; e.sel = 5'(i); e.busy = 1'b1; e.to = 1'b0;
        return e;
    endfunction

    function automatic exp_t idle(input logic to, input string tag);
        exp_t e;
        e.id = 0; e.tag = tag;
        e.grant = '0; e.sel = 5'd31; e.busy = 1'b0; e.to = to;
        return e;
    endfunction

    task automatic step(input int id, input logic [23:0] r, input exp_t e);
        exp_t x;
        if (id == 0) req_a = r; else req_b = r;
        e.id = id;
        sb.push_back(e);
        @(posedge clock);
        #1;
        x = sb.pop_front();
        if (x.id == 0) begin
            check({x.tag, ".grant"},   grant_a,       x.grant);
            check({x.tag, ".sel"},     32'(sel_a),    32'(x.sel));
            check({x.tag, ".busy"},    32'(busy_a),   32'(x.busy));
            check({x.tag, ".timeout"}, 32'(to_a),     32'(x.to));
        end else begin
            check({x.tag, ".grant"},   grant_b,       x.grant);
            check({x.tag, ".sel"},     32'(sel_b),    32'(x.sel));
            check({x.tag, ".busy"},    32'(busy_b),   32'(x.busy));
            check({x.tag, ".timeout"}, 32'(to_b),     32'(x.to));
        end
    endtask

    task automatic check_inv(input string tag, input logic [31:0] gr, input logic [4:0] sel,
                             input logic bsy);
        logic [4:0] want;
        want = 5'd31;
        for (int i = 0; i < 32; i++) if (gr[i]) want = 5'(i);
        check({tag, ".hi"},     32'(gr[31:24]),     32'd0);
        check({tag, ".onehot"}, 32'($onehot0(gr)),  32'd1);
        check({tag, ".sel"},    32'(sel),           32'(want));
        check({tag, ".busy"},   32'(bsy),           32'(gr != 32'd0));
    endtask

    initial begin
        int w;
        logic [23:0] r;
        clear = 1'b1;
        req_a = '0;
        req_b = '0;
        #12;
        check("rst.grant",   grant_a,     32'd0);
        check("rst.sel",     32'(sel_a),  32'd31);
        check("rst.busy",    32'(busy_a), 32'd0);
        check("rst.timeout", 32'(to_a),   32'd0);
        check("rst.sel_b",   32'(sel_b),  32'd31);
        @(negedge clock);
        clear = 1'b0;

        // Two requesters, owner releases after one cycle and re-raises.
        w = 1;
        for (int k = 0; k < 6; k++) begin
            step(0, 24'h6, g(w, "pri.own"));
            r = 24'h6;
            r[w] = 1'b0;
            step(0, r, idle(1'b0, "pri.turn"));
`ifndef BUS_ARB_FIXED_PRI_EN
            w = (w == 1) ? 2 : 1;
`endif
        end
        step(0, 24'h0, idle(1'b0, "pri.idle"));

        // Continuous single request: 8 grant cycles then one dead cycle with timeout.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 8; i++) step(0, 24'h20, g(5, "hold.own"));
            step(0, 24'h20, idle(1'b1, "hold.timeout"));
        end
        step(0, 24'h0, idle(1'b0, "hold.idle"));

        // Owner 23 drops while 0 and 5 wait: wrap to 0.
        step(0, 24'h800000, g(23, "wrap.own"));
        step(0, 24'h800021, g(23, "wrap.others"));
        step(0, 24'h000021, idle(1'b0, "wrap.turn"));
        step(0, 24'h000021, g(0, "wrap.win0"));
        step(0, 24'h000020, idle(1'b0, "wrap.drop"));
        step(0, 24'h000000, idle(1'b0, "wrap.idle"));

        // Asynchronous reset in the middle of a grant.
        step(0, 24'h4, g(2, "arst.own"));
        #2 clear = 1'b1;
        #1;
        check("arst.grant",   grant_a,     32'd0);
        check("arst.sel",     32'(sel_a),  32'd31);
        check("arst.busy",    32'(busy_a), 32'd0);
        check("arst.timeout", 32'(to_a),   32'd0);
        #1 clear = 1'b0;
        step(0, 24'h1, g(0, "arst.after"));
        step(0, 24'h0, idle(1'b0, "arst.turn"));
        step(0, 24'h0, idle(1'b0, "arst.idle"));

        // Round robin over 0..2 with no hold limit.
        step(1, 24'h7, g(0, "rr.o0a"));
        step(1, 24'h7, g(0, "rr.o0b"));
        step(1, 24'h6, idle(1'b0, "rr.t0"));
        step(1, 24'h7, g(1, "rr.o1a"));
        step(1, 24'h7, g(1, "rr.o1b"));
        step(1, 24'h5, idle(1'b0, "rr.t1"));
        step(1, 24'h7, g(2, "rr.o2a"));
        step(1, 24'h7, g(2, "rr.o2b"));
        step(1, 24'h3, idle(1'b0, "rr.t2"));
        step(1, 24'h7, g(0, "rr.o0c"));
        for (int i = 0; i < 14; i++) step(1, 24'h7, g(0, "rr.nolimit"));
        step(1, 24'h0, idle(1'b0, "rr.turn"));
        step(1, 24'h0, idle(1'b0, "rr.idle"));

        // Random request traffic: structural invariants every cycle.
        for (int c = 0; c < 10000; c++) begin
            r = 24'($urandom());
            if (c % 3 == 0) r = r & 24'($urandom()) & 24'($urandom());
            req_a = r;
            req_b = 24'($urandom()) & 24'($urandom());
            @(posedge clock);
            #1;
            check_inv("rnd.a", grant_a, sel_a, busy_a);
            check_inv("rnd.b", grant_b, sel_b, busy_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
